div_64: RTL
===========

Name: div_64

Overview:
- Sequential integer divider; the inverse of the team's combinational 32x32→64 multiplier.
- Computes a 32-bit quotient and a 32-bit remainder from a 32-bit dividend and 32-bit divisor, signed or unsigned.
- Restoring shift-subtract algorithm, one quotient bit per clock.
- Sits beside the multiplier in the execute stage and serves DIV/DIVU/REM/REMU with a start/done handshake.

Parameters:
- WIDTH, 32, operand/quotient/remainder width.
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start_in  input  1  request; sampled only in IDLE.
- dividend_in  input  WIDTH  dividend, captured when start is accepted.
- divisor_in  input  WIDTH  divisor, captured when start is accepted.
- is_signed_div  input  1  1 = signed (two's complement), 0 = unsigned; captured with the operands.
- quotient_out  output  WIDTH  registered quotient.
- remainder_out  output  WIDTH  registered remainder.
- busy_out  output  1  high while an operation is in flight.
- done_out  output  1  one-cycle pulse when results are valid.

Behaviour:
- Reset (rst high at a clock edge): state→IDLE; quotient_out=0, remainder_out=0, busy_out=0, done_out=0; counter and internal registers cleared. Reset mid-operation aborts the operation with no done pulse.
- States:
  - IDLE: start_in=1 at edge E0 captures operands and the sign flag.
    - Signed mode: stores |dividend| and |divisor|, plus neg_q = sign(dividend) XOR sign(divisor) and neg_r = sign(dividend).
    - Clears the partial remainder; counter=0; →DIVIDE; busy_out=1 from E0.
  - DIVIDE: once per edge:
    - Shift {rem, quo} left by 1, bringing in the dividend MSB.
    - Trial subtract rem − divisor at WIDTH+1 bits.
    - Non-negative result: rem=difference, quotient LSB=1. Negative result: rem unchanged, LSB=0.
    - Counter increments; after WIDTH iterations (edges E1..E32) →FINISH.
  - FINISH (edge E33): applies sign correction, loads quotient_out/remainder_out, done_out=1 for exactly one cycle, busy_out=0, →IDLE.
- Latency:
  - done_out is visible in the cycle after E33 (34 edges after acceptance).
  - Back-to-back: start_in may be high in the same cycle done_out is high; it is accepted at the next edge.
- start_in while busy_out=1: ignored; the operation is not disturbed.
- Outputs hold their last values until the next FINISH; operand inputs are don't-care after acceptance.
- Sign correction (signed mode only):
  - Quotient is negated if neg_q.
  - Remainder is negated if neg_r.
  - The remainder sign always follows the dividend.
- Divide by zero (divisor=0, either mode): quotient_out = all ones (0xFFFFFFFF), remainder_out = original dividend; no sign correction applied.
- Signed overflow (dividend=0x80000000, divisor=0xFFFFFFFF, signed): quotient_out=0x80000000, remainder_out=0.
- Absolute value of 0x80000000 is handled as unsigned 0x80000000; the internal datapath is WIDTH+1 bits to avoid overflow.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: in IDLE, a divide-by-zero or signed-overflow request skips DIVIDE and goes directly to FINISH. Results are as specified above; done_out is visible one cycle after E1 (2 edges after acceptance).
- Undefined: all requests take the fixed 34-edge latency; special-case results are produced in FINISH.

Test Plan:
- Unsigned: dividend=100, divisor=7, is_signed_div=0 → quotient_out=14, remainder_out=2; done_out is a single-cycle pulse 34 edges after acceptance; busy_out high for the preceding 33 cycles.
- Signed: dividend=−7 (0xFFFFFFF9), divisor=2 → quotient_out=0xFFFFFFFD (−3), remainder_out=0xFFFFFFFF (−1). Then dividend=7, divisor=−2 → quotient −3, remainder +1.
- Divide by zero: dividend=0x12345678, divisor=0, both modes → quotient_out=0xFFFFFFFF, remainder_out=0x12345678. Latency is 34 edges without DIV_EARLY_OUT_EN and 2 edges with it.
- Overflow: dividend=0x80000000, divisor=0xFFFFFFFF, signed → quotient_out=0x80000000, remainder_out=0.
- Same operands unsigned → quotient_out=0, remainder_out=0x80000000.
- Control:
  - Pulse start_in again at cycle 10 of an operation → ignored; the result is unchanged.
  - Assert rst at cycle 20 of another operation → no done_out; all outputs 0; a fresh start then completes normally.
  - Back-to-back start in the done cycle → second result arrives 34 edges later.

Source files
------------

// File: rtl/div_64.sv
`default_nettype none
// ============================================================================
// Module      : div_64
// Description : Sequential restoring divider, one quotient bit per clock.
//               Signed or unsigned WIDTH/WIDTH division producing a
//               WIDTH-bit quotient and remainder with a start/done handshake.
//               Optional build macro DIV_EARLY_OUT_EN: divide-by-zero and
//               signed-overflow requests bypass the iteration loop.
// Revision    : 1.0 - initial release
// ============================================================================
module div_64 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_in,
  input  logic [WIDTH-1:0] dividend_in,
  input  logic [WIDTH-1:0] divisor_in,
  input  logic             is_signed_div,
  output logic [WIDTH-1:0] quotient_out,
  output logic [WIDTH-1:0] remainder_out,
  output logic             busy_out,
  output logic             done_out
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIVIDE = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_last_iter = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] c_min_neg   = {1'b1, {(WIDTH-1){1'b0}}};

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH:0]     r_rem;       // partial remainder, one guard bit
  logic [WIDTH-1:0]   r_quo;       // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0]   r_dvs;       // divisor magnitude
  logic [WIDTH-1:0]   r_dvd_orig;  // untouched dividend for the divide-by-zero result
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_div0;
  logic               r_ovf;

  logic               w_dvd_neg;
  logic               w_dvs_neg;
  logic [WIDTH-1:0]   w_dvd_abs;
  logic [WIDTH-1:0]   w_dvs_abs;
  logic               w_div0;
  logic               w_ovf;
  logic [WIDTH+1:0]   w_shift;
  logic [WIDTH+1:0]   w_trial;
  logic               w_trial_neg;

  // Operand magnitudes and special-case detection at the request boundary.
  // Negating the most negative value yields the same bit pattern, which is
  // exactly its correct unsigned magnitude.
  always_comb begin
    w_dvd_neg = is_signed_div & dividend_in[WIDTH-1];
    w_dvs_neg = is_signed_div & divisor_in[WIDTH-1];
    w_dvd_abs = w_dvd_neg ? (~dividend_in + 1'b1) : dividend_in;
    w_dvs_abs = w_dvs_neg ? (~divisor_in + 1'b1) : divisor_in;
    w_div0    = (divisor_in == '0);
    w_ovf     = is_signed_div && (dividend_in == c_min_neg) && (divisor_in == '1);
  end

  // One restoring step: shift in the next dividend bit and trial-subtract.
  // The extra top bit of the difference is the borrow that rejects the step.
  always_comb begin
    w_shift     = {r_rem, r_quo[WIDTH-1]};
    w_trial     = w_shift - {2'b00, r_dvs};
    w_trial_neg = w_trial[WIDTH+1];
  end

  // Control FSM and datapath registers, including the registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_rem         <= '0;
      r_quo         <= '0;
      r_dvs         <= '0;
      r_dvd_orig    <= '0;
      r_neg_q       <= 1'b0;
      r_neg_r       <= 1'b0;
      r_div0        <= 1'b0;
      r_ovf         <= 1'b0;
      quotient_out  <= '0;
      remainder_out <= '0;
      busy_out      <= 1'b0;
      done_out      <= 1'b0;
    end else begin
      done_out <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_in) begin
            r_quo      <= w_dvd_abs;
            r_dvs      <= w_dvs_abs;
            r_rem      <= '0;
            r_cnt      <= '0;
            r_neg_q    <= w_dvd_neg ^ w_dvs_neg;
            r_neg_r    <= w_dvd_neg;
            r_dvd_orig <= dividend_in;
            r_div0     <= w_div0;
            r_ovf      <= w_ovf;
            busy_out   <= 1'b1;
`ifdef DIV_EARLY_OUT_EN
            r_state    <= (w_div0 || w_ovf) ? S_FINISH : S_DIVIDE;
`else
            r_state    <= S_DIVIDE;
`endif
          end
        end

        S_DIVIDE: begin
          if (w_trial_neg) begin
            r_rem <= w_shift[WIDTH:0];
            r_quo <= {r_quo[WIDTH-2:0], 1'b0};
          end else begin
            r_rem <= w_trial[WIDTH:0];
            r_quo <= {r_quo[WIDTH-2:0], 1'b1};
          end
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == c_last_iter) begin
            r_state <= S_FINISH;
          end
        end

        S_FINISH: begin
          if (r_div0) begin
            quotient_out  <= '1;
            remainder_out <= r_dvd_orig;
          end else if (r_ovf) begin
            quotient_out  <= c_min_neg;
            remainder_out <= '0;
          end else begin
            quotient_out  <= r_neg_q ? (~r_quo + 1'b1) : r_quo;
            remainder_out <= r_neg_r ? (~r_rem[WIDTH-1:0] + 1'b1) : r_rem[WIDTH-1:0];
          end
          done_out <= 1'b1;
          busy_out <= 1'b0;
          r_state  <= S_IDLE;
        end

        default: begin
          r_state  <= S_IDLE;
          busy_out <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
